// File: rtl/regmodel0_regmodel_ocp2_slave.sv
// OCP2 target engine for the regmodel0 SW port: one OCP read/write at a time is
// turned into a single register-bank req/ack access, with a backend timeout.
module regmodel0_regmodel_ocp2_slave #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreset_n,
    input  logic [2:0]  mcmd,
    input  logic [14:0] maddr,
    input  logic [3:0]  mbyteen,
    input  logic [5:0]  mreqinfo,
    input  logic [31:0] mdata,
    input  logic        mrespaccept,
    output logic        scmdaccept,
    output logic [1:0]  sresp,
    output logic [31:0] sdata,
    output logic        reg_req,
    output logic        reg_wr,
    output logic [14:0] reg_addr,
    output logic [3:0]  reg_be,
    output logic [31:0] reg_wdata,
    output logic [5:0]  reg_info,
    input  logic        reg_ack,
    input  logic        reg_err,
    input  logic [31:0] reg_rdata,
    output logic [1:0]  state_dbg
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_WR   = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WRNP = 3'd5;

    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          cmd_is_wr;
    logic          timed_out;

    // Handshake: a command is taken on any cycle where scmdaccept=1 and mcmd!=IDLE;
    // a response is held until the cycle where sresp!=NULL and mrespaccept=1.
    assign scmdaccept = (state == S_IDLE) & ~reset & mreset_n;
    assign cmd_is_wr  = (mcmd == CMD_WR) || (mcmd == CMD_WRNP);
    assign timed_out  = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (reset || !mreset_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            sresp     <= RESP_NULL;
            sdata     <= '0;
            reg_req   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_be    <= '0;
            reg_wdata <= '0;
            reg_info  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mcmd != CMD_IDLE) begin
                        reg_addr  <= {maddr[14:2], 2'b00};
                        reg_be    <= mbyteen;
                        reg_wdata <= mdata;
                        reg_info  <= mreqinfo;
                        reg_wr    <= cmd_is_wr;
                        wait_cnt  <= '0;
                        if (mcmd == CMD_RD || (cmd_is_wr && mbyteen != 4'd0)) begin
                            reg_req <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            // Empty write completes without touching the bank.
                            sresp <= cmd_is_wr ? RESP_DVA : RESP_ERR;
                            sdata <= '0;
                            state <= S_RESP;
                        end
                    end
                end
                S_REQ: begin
                    if (reg_ack) begin
                        reg_req <= 1'b0;
                        sresp   <= reg_err ? RESP_ERR : RESP_DVA;
                        sdata   <= (!reg_err && !reg_wr) ? reg_rdata : 32'd0;
                        state   <= S_RESP;
                    end else if (timed_out) begin
                        reg_req <= 1'b0;
                        sresp   <= RESP_ERR;
                        sdata   <= '0;
                        state   <= S_RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (mrespaccept) begin
                        sresp <= RESP_NULL;
                        sdata <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/regmodel0_regmodel_ocp2_slave.md
# regmodel0_regmodel_ocp2_slave

OCP2 target-side protocol engine for the regmodel0 SW access port. It accepts single OCP2 read/write commands from the fabric master, converts each into one access on a simple register-bank request/ack bus, and returns a response with backpressure via mrespaccept. It sits between the OCP2 slave modport and the generated register bank, one outstanding transaction at a time, with a backend timeout.

## Interface
- TIMEOUT, 255: max cycles reg_req may wait for reg_ack before ERR response; 0 disables timeout.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mreset_n  in  1  OCP reset, active-low, synchronous; low has same effect as reset
- mcmd  in  3  OCP command: 0 IDLE, 1 WR, 2 RD, 5 WRNP, others unsupported
- maddr  in  15  byte address
- mbyteen  in  4  byte enables
- mreqinfo  in  6  request info, passed to backend
- mdata  in  32  write data
- mrespaccept  in  1  master accepts response
- scmdaccept  out  1  command accepted this cycle
- sresp  out  2  0 NULL, 1 DVA, 2 FAIL, 3 ERR
- sdata  out  32  read data
- reg_req  out  1  backend request, held until reg_ack or timeout
- reg_wr  out  1  1 write, 0 read
- reg_addr  out  15  {maddr[14:2], 2'b00}
- reg_be  out  4  captured mbyteen
- reg_wdata  out  32  captured mdata
- reg_info  out  6  captured mreqinfo
- reg_ack  in  1  backend done, sampled only while reg_req=1
- reg_err  in  1  backend error, qualified by reg_ack
- reg_rdata  in  32  read data, qualified by reg_ack

## Operation
- States: IDLE, REQ, RESP. Reset state IDLE.
- scmdaccept = (state==IDLE) & ~reset & mreset_n; command taken when scmdaccept & mcmd!=0.
- On accept: capture addr/be/data/info/cmd into registers.
  - RD, WR, WRNP with mbyteen!=0 -> REQ.
  - WR/WRNP with mbyteen==0 -> RESP, sresp=DVA, no backend access.
  - RD with mbyteen==0 -> REQ (full read performed, be forwarded as 0).
  - mcmd 3,4,6,7 -> RESP, sresp=ERR, sdata=0, no backend access.
- REQ: reg_req=1, reg_wr=1 for WR/WRNP. Wait counter increments each REQ cycle.
  - reg_ack & ~reg_err -> RESP, sresp=DVA, sdata=reg_rdata for RD, 0 for writes.
  - reg_ack & reg_err -> RESP, sresp=ERR, sdata=0.
  - counter reaches TIMEOUT without ack -> RESP, sresp=ERR, sdata=0; reg_req drops.
  - ack and timeout in same cycle: ack wins.
- RESP: sresp/sdata held stable until mrespaccept=1, then sresp=NULL, sdata=0, -> IDLE.
- Counter width $clog2(TIMEOUT+1), min 1; cleared on entry to REQ; saturates, no wrap.
- reg_ack while reg_req=0 ignored.
- reset or mreset_n=0 in any state: next cycle state IDLE, reg_req=0, sresp=NULL, counter=0; in-flight transaction abandoned, no response.

## Timing
- Reset values: scmdaccept 0 (while reset), sresp 0, sdata 0, reg_req 0, reg_wr 0, reg_addr 0, reg_be 0, reg_wdata 0, reg_info 0.
- Cycle 0 accept; cycle 1 reg_req=1; ack in cycle 1+N -> sresp valid cycle 2+N.
- Min latency accept-to-sresp: 2 cycles (backend access), 1 cycle (no-access cases).
- Timeout: reg_req high for exactly TIMEOUT cycles; sresp=ERR the following cycle.
- mrespaccept high in first RESP cycle -> IDLE next cycle; next accept possible that cycle. Min 3 cycles per transaction.
- All outputs registered, except scmdaccept (decoded from state and resets).

## Test plan
- RD maddr=0x0104, be=0xF; reg_ack+reg_rdata=0xA5A5_1234 in first REQ cycle -> reg_addr=0x0104, sresp=DVA, sdata=0xA5A5_1234, two cycles after accept.
- WR maddr=0x0013, be=0x3, mdata=0x1122_3344 -> reg_addr=0x0010, reg_wr=1, reg_be=0x3, reg_wdata=0x1122_3344; after ack sresp=DVA, sdata=0.
- TIMEOUT=4, RD with no reg_ack -> reg_req high exactly 4 cycles, then sresp=ERR, sdata=0.
- mcmd=3 -> accepted, reg_req never asserts, sresp=ERR one cycle later; WR with be=0 -> sresp=DVA, no reg_req.
- Response held with mrespaccept=0 for 5 cycles -> sresp/sdata stable, scmdaccept=0; new RD presented is not accepted until the cycle after mrespaccept=1.
- reset asserted mid-REQ with reg_ack pending -> next cycle reg_req=0, sresp=NULL, scmdaccept=1 after reset deasserts; repeat with mreset_n=0, same result.
